uart_rx_buffered: RTL and testbench
===================================

Name: uart_rx_buffered

Overview:
- UART receiver with a receive FIFO; the receive-side counterpart of uart_tx, using the same frame: 8N1, LSB first, idle-high line.
- Samples each bit at mid-bit using the shared baud_div convention: baud_div = clk_freq/baud - 1, so one bit period is baud_div+1 clocks.
- Received bytes are buffered in a show-ahead FIFO that uart_top's register interface drains.
- Framing and overrun errors are reported through sticky flags.

Parameters:
- DEPTH, 16, FIFO depth in bytes; must be a power of two, minimum 2.
- SYNC_STAGES, 2, number of flip-flops in the rx_i synchronizer; minimum 2.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- rx_i  in  1  serial input line, asynchronous to clk_i
- baud_div  in  16  clocks per bit minus 1; must be >= 3 and held stable while rx_en_i=1
- rx_en_i  in  1  receiver enable
- rd_i  in  1  pop the FIFO head; ignored when empty
- clr_err_i  in  1  clear both sticky error flags
- dout_o  out  8  FIFO head byte, valid when empty_o=0
- empty_o  out  1  FIFO empty
- full_o  out  1  FIFO full
- count_o  out  $clog2(DEPTH)+1  number of bytes in the FIFO
- rx_busy_o  out  1  high whenever the FSM is not in IDLE
- frame_err_o  out  1  sticky: a stop bit was sampled low
- overrun_o  out  1  sticky: a received byte was dropped because the FIFO was full

Behaviour:
- Reset: the synchronizer flops reset to 1. FSM goes to IDLE; counters and pointers go to 0.
- Output reset values: dout_o=0, empty_o=1, full_o=0, count_o=0, rx_busy_o=0, frame_err_o=0, overrun_o=0.
- Only the synchronized signal rxs is used internally; rx_i is never sampled directly.
- The baud counter tick_cnt is 16 bits and counts up to a terminal value, then reloads to 0.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when rx_en_i=1 and rxs=0, go to START with tick_cnt=0.
  - START: when tick_cnt = baud_div>>1 (mid start bit), check rxs. If rxs=0, go to DATA with tick_cnt=0 and bit_idx=0. If rxs=1, treat it as a glitch and return to IDLE.
  - DATA: when tick_cnt = baud_div, shift rxs into shreg[7] (right shift, so the first bit ends at shreg[0]). When bit_idx=7, go to STOP; otherwise increment bit_idx.
  - STOP: when tick_cnt = baud_div, check rxs. If rxs=1, push shreg into the FIFO and go to IDLE. If rxs=0, set frame_err_o, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH (break or line held low): return to IDLE once rxs=1.
- rx_en_i=0 in any state forces IDLE on the next clock. A partial byte is discarded; FIFO contents and error flags are preserved.
- Latency: empty_o deasserts on the clock after the stop-bit sample (registered outputs). For baud_div=99 this is 953±2 clocks after the falling start edge on rx_i.
- FIFO push when full: the push is dropped and overrun_o sets, unless rd_i=1 in the same cycle. In that case the pop and push both occur, count_o is unchanged and there is no overrun.
- Push and pop in the same cycle when the FIFO is non-empty: count_o is unchanged.
- FIFO pop when empty: no effect.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; full/empty are derived from count_o.
- dout_o is show-ahead: mem[rd_ptr] is registered so that it is valid whenever empty_o=0.
- Sticky flags: clr_err_i clears both. If clr_err_i coincides with a new error event, the set wins.

Decomposition:
- uart_pkg holds:
  - enum rx_state_t {IDLE, START, DATA, STOP, WAIT_HIGH}
  - UART_DATA_BITS = 8
  - typedef baud_div_t = logic [15:0], shared with uart_tx.
- Sub-module uart_rx_fifo: generic synchronous show-ahead FIFO parameterised by DEPTH and width; the FSM lives in the top of this block.

Test Plan:
- Loopback from uart_tx with baud_div=99, sending 0xA4 -> empty_o falls ~953 clocks after the start edge; dout_o=0xA4, count_o=1, no error flags.
- Start glitch: rx_i low for 20 clocks then high, baud_div=99 -> FSM returns to IDLE; empty_o stays 1; frame_err_o=0.
- Framing error: frame 0x55 with stop bit 0, line released high 300 clocks later -> frame_err_o=1, FIFO unchanged, FSM passes WAIT_HIGH then IDLE; next valid 0x3C is received correctly; clr_err_i pulse -> frame_err_o=0.
- Overrun with DEPTH=16: send 17 bytes 0x00..0x10 with no reads -> full_o=1, count_o=16, overrun_o=1; 16 pops yield 0x00..0x0F in order; then empty_o=1.
- Full with simultaneous pop: FIFO full, rd_i asserted in the push cycle -> count_o stays 16, overrun_o stays 0, the new byte ends up at the tail.
- Mid-frame disable: deassert rx_en_i during data bit 4, re-enable before the next frame, send 0xE7 -> only 0xE7 is received, count_o=1, no error flags.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and the baud divider type.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
    localparam int UART_DATA_BITS = 8;
    typedef logic [15:0] baud_div_t;
endpackage

// File: rtl/uart_rx_buffered_if.sv
// Host-side bus of the buffered UART receiver: FIFO drain, status and sticky error flags.
interface uart_rx_buffered_if import uart_pkg::*; #(parameter int DEPTH = 16);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                      rd_i;
    logic                      clr_err_i;
    logic [UART_DATA_BITS-1:0] dout_o;
    logic                      empty_o;
    logic                      full_o;
    logic [CW-1:0]             count_o;
    logic                      rx_busy_o;
    logic                      frame_err_o;
    logic                      overrun_o;

    modport master (
        output rd_i, clr_err_i,
        input  dout_o, empty_o, full_o, count_o, rx_busy_o, frame_err_o, overrun_o
    );
    modport slave (
        input  rd_i, clr_err_i,
        output dout_o, empty_o, full_o, count_o, rx_busy_o, frame_err_o, overrun_o
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO; the head word is registered so it is valid whenever not empty.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
    logic [AW:0]      count_n;
    logic             do_push, do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_push  = push && (!full || do_pop);
    assign drop     = push && !do_push;
    assign rd_ptr_n = do_pop ? rd_ptr + AW'(1) : rd_ptr;

    always_comb begin
        count_n = count;
        if (do_push && !do_pop)
            count_n = count + (AW+1)'(1);
        else if (!do_push && do_pop)
            count_n = count - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            // New head may be the word being written this cycle (bypass the memory).
            if (count_n != '0)
                dout <= (do_push && (rd_ptr_n == wr_ptr)) ? din : mem[rd_ptr_n];
        end
    end
endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with mid-bit sampling, receive FIFO and sticky framing/overrun flags.
module uart_rx_buffered import uart_pkg::*; #(
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                rx_i,
    input  baud_div_t           baud_div,
    input  logic                rx_en_i,
    uart_rx_buffered_if.slave   bus
);
    logic [SYNC_STAGES-1:0]    sync_q;
    logic                      rxs;
    rx_state_t                 state, state_n;
    baud_div_t                 tick_cnt, tick_n;
    logic [2:0]                bit_idx, bit_n;
    logic [UART_DATA_BITS-1:0] shreg, shreg_n;
    logic                      push, frame_set, fifo_drop;
    logic                      frame_err, overrun;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            sync_q <= '1;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
    assign rxs = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_n   = state;
        tick_n    = tick_cnt + 16'd1;
        bit_n     = bit_idx;
        shreg_n   = shreg;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state)
            IDLE: begin
                tick_n = '0;
                if (!rxs)
                    state_n = START;
            end
            START: begin
                if (tick_cnt == (baud_div >> 1)) begin
                    tick_n  = '0;
                    bit_n   = '0;
                    state_n = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick_cnt == baud_div) begin
                    tick_n  = '0;
                    shreg_n = {rxs, shreg[UART_DATA_BITS-1:1]};
                    if (bit_idx == 3'(UART_DATA_BITS - 1))
                        state_n = STOP;
                    else
                        bit_n = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (tick_cnt == baud_div) begin
                    tick_n = '0;
                    if (rxs) begin
                        push    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_n   = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                tick_n = '0;
                if (rxs)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Disabling abandons any frame in flight; buffered bytes and flags stay.
        if (!rx_en_i) begin
            state_n   = IDLE;
            tick_n    = '0;
            push      = 1'b0;
            frame_set = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_idx  <= bit_n;
            if (frame_set)
                frame_err <= 1'b1;
            else if (bus.clr_err_i)
                frame_err <= 1'b0;
            if (fifo_drop)
                overrun <= 1'b1;
            else if (bus.clr_err_i)
                overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        shreg <= shreg_n;
    end

    uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(UART_DATA_BITS)) u_fifo (
        .clk   (clk_i),
        .rstn  (rstn_i),
        .push  (push),
        .din   (shreg),
        .pop   (bus.rd_i),
        .dout  (bus.dout_o),
        .empty (bus.empty_o),
        .full  (bus.full_o),
        .count (bus.count_o),
        .drop  (fifo_drop)
    );

    assign bus.rx_busy_o   = (state != IDLE);
    assign bus.frame_err_o = frame_err;
    assign bus.overrun_o   = overrun;
endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench for uart_rx_buffered: serial frames in, FIFO bytes checked by a monitor.
module tb_uart_rx_buffered;
    import uart_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rx = 1'b1;
    logic        rx_en = 1'b0;
    baud_div_t   bd = 16'd99;
    logic        mon_rd = 1'b0;
    logic        stim_rd = 1'b0;
    logic        clr_err = 1'b0;
    logic        drain = 1'b0;
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int unsigned last_fall = 0;
    logic        prev_empty = 1'b1;
    logic [7:0]  exp_q[$];

    uart_rx_buffered_if #(.DEPTH(DEPTH)) bus();
    assign bus.rd_i      = mon_rd | stim_rd;
    assign bus.clr_err_i = clr_err;

    uart_rx_buffered #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk_i    (clk),
        .rstn_i   (rstn),
        .rx_i     (rx),
        .baud_div (bd),
        .rx_en_i  (rx_en),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every byte presented while draining is compared against the scoreboard and popped.
    always @(negedge clk) begin
        mon_rd = 1'b0;
        if (prev_empty && !bus.empty_o)
            last_fall = cyc;
        prev_empty = bus.empty_o;
        if (drain && !bus.empty_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: got unexpected byte 0x%0h, expected none", bus.dout_o);
            end else begin
                check("sb_data", int'(bus.dout_o), int'(exp_q.pop_front()));
            end
            mon_rd = 1'b1;
        end
    end

    task automatic clocks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame starting right after an edge. pop_at_stop raises rd_i exactly on the
    // stop-sample edge; dis_bit drops rx_en_i in the middle of that frame bit (0 = start bit).
    task automatic send_frame(input logic [7:0] d, input logic stop, input bit pop_at_stop,
                              input int dis_bit);
        int p;
        int pop_edge;
        int e;
        logic [9:0] bits;
        p        = int'(bd) + 1;
        pop_edge = 3 + (int'(bd) >> 1) + 1 + 9 * p;
        bits     = {stop, d, 1'b0};
        e        = 0;
        for (int k = 0; k < 10; k++) begin
            rx = bits[k];
            for (int c = 0; c < p; c++) begin
                if (pop_at_stop) begin
                    stim_rd = (e + 1 == pop_edge);
                    if (stim_rd)
                        check("pop_head", int'(bus.dout_o), int'(exp_q.pop_front()));
                end
                if (k == dis_bit && c == p / 2)
                    rx_en = 1'b0;
                @(posedge clk);
                #1;
                e++;
            end
        end
        stim_rd = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            clocks(1);
            n++;
        end
        check("drain_done", exp_q.size(), 0);
        clocks(2);
    endtask

    task automatic set_baud(input baud_div_t v);
        rx_en = 1'b0;
        clocks(1);
        bd = v;
        clocks(1);
        rx_en = 1'b1;
        clocks(2);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0;
        int lat;

        clocks(3);
        check("rst_dout", int'(bus.dout_o), 0);
        check("rst_empty", int'(bus.empty_o), 1);
        check("rst_full", int'(bus.full_o), 0);
        check("rst_count", int'(bus.count_o), 0);
        check("rst_busy", int'(bus.rx_busy_o), 0);
        check("rst_ferr", int'(bus.frame_err_o), 0);
        check("rst_ovr", int'(bus.overrun_o), 0);
        rstn = 1'b1;
        clocks(2);
        set_baud(16'd99);

        // Single byte with latency measurement from the falling start edge.
        c0 = cyc;
        send_frame(8'hA4, 1'b1, 1'b0, -1);
        clocks(5);
        lat = int'(last_fall - c0);
        checks++;
        if (lat < 951 || lat > 955) begin
            errors++;
            $display("FAIL latency: got %0d clocks, expected 953+-2", lat);
        end
        check("a4_count", int'(bus.count_o), 1);
        check("a4_ferr", int'(bus.frame_err_o), 0);
        check("a4_ovr", int'(bus.overrun_o), 0);
        check("a4_busy", int'(bus.rx_busy_o), 0);
        exp_q.push_back(8'hA4);
        drain = 1'b1;
        wait_drain();
        check("a4_empty", int'(bus.empty_o), 1);

        // Start glitch.
        rx = 1'b0;
        clocks(20);
        rx = 1'b1;
        clocks(200);
        check("glitch_busy", int'(bus.rx_busy_o), 0);
        check("glitch_empty", int'(bus.empty_o), 1);
        check("glitch_ferr", int'(bus.frame_err_o), 0);

        // Framing error, line held low, then recovery.
        send_frame(8'h55, 1'b0, 1'b0, -1);
        clocks(300);
        check("fe_flag", int'(bus.frame_err_o), 1);
        check("fe_busy_wait", int'(bus.rx_busy_o), 1);
        check("fe_empty", int'(bus.empty_o), 1);
        rx = 1'b1;
        clocks(5);
        check("fe_idle", int'(bus.rx_busy_o), 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        clocks(5);
        wait_drain();
        check("fe_sticky", int'(bus.frame_err_o), 1);
        clr_err = 1'b1;
        clocks(1);
        clr_err = 1'b0;
        check("fe_cleared", int'(bus.frame_err_o), 0);

        // Overrun: 17 bytes into a 16-deep FIFO with no reads.
        drain = 1'b0;
        set_baud(16'd15);
        for (int i = 0; i < 17; i++)
            send_frame(8'(i), 1'b1, 1'b0, -1);
        clocks(5);
        check("ovr_full", int'(bus.full_o), 1);
        check("ovr_count", int'(bus.count_o), 16);
        check("ovr_flag", int'(bus.overrun_o), 1);
        for (int i = 0; i < 16; i++)
            exp_q.push_back(8'(i));
        drain = 1'b1;
        wait_drain();
        check("ovr_empty", int'(bus.empty_o), 1);
        check("ovr_count0", int'(bus.count_o), 0);
        clr_err = 1'b1;
        clocks(1);
        clr_err = 1'b0;
        check("ovr_cleared", int'(bus.overrun_o), 0);

        // Full FIFO with a pop on the push cycle.
        drain = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'h20 + 8'(i));
            send_frame(8'h20 + 8'(i), 1'b1, 1'b0, -1);
        end
        clocks(3);
        check("fp_full", int'(bus.full_o), 1);
        send_frame(8'h30, 1'b1, 1'b1, -1);
        exp_q.push_back(8'h30);
        clocks(3);
        check("fp_count", int'(bus.count_o), 16);
        check("fp_ovr", int'(bus.overrun_o), 0);
        check("fp_still_full", int'(bus.full_o), 1);
        drain = 1'b1;
        wait_drain();
        check("fp_empty", int'(bus.empty_o), 1);

        // Disable during data bit 4, then a clean frame.
        drain = 1'b0;
        set_baud(16'd99);
        send_frame(8'h00, 1'b1, 1'b0, 5);
        clocks(3);
        check("dis_busy", int'(bus.rx_busy_o), 0);
        check("dis_count", int'(bus.count_o), 0);
        rx_en = 1'b1;
        clocks(10);
        send_frame(8'hE7, 1'b1, 1'b0, -1);
        clocks(5);
        check("dis_count1", int'(bus.count_o), 1);
        check("dis_ferr", int'(bus.frame_err_o), 0);
        check("dis_ovr", int'(bus.overrun_o), 0);
        exp_q.push_back(8'hE7);
        drain = 1'b1;
        wait_drain();
        check("dis_empty", int'(bus.empty_o), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
